// File: rtl/blu_pkg.sv
// Shared BLU datapath types: add/subtract opcode, slice width and the
// compare-flag bundle produced by the subtract/compare pipeline.
package blu_pkg;

  typedef enum logic {BLU_ADD = 1'b0, BLU_SUB = 1'b1} blu_addsub_e;

  localparam int SLICE_W = 16;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic lt_u;
    logic lt_s;
  } blu_flags_t;

endpackage

// File: rtl/bk_sub32_pipe_adder.sv
// 16-bit Brent-Kung parallel-prefix adder slice with carry-in/carry-out
// so two slices can be chained through a pipeline register.
module BK_adder_16bit
  import blu_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               carry_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               carry_o
);

  localparam int LEVELS = $clog2(SLICE_W);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] gg;
  logic [SLICE_W-1:0] pp;
  logic [LEVELS-1:0]  k;

  assign p = a_i ^ b_i;

  // Carry-in is folded into bit 0's generate, so every group term is a full carry.
  always_comb begin
    gg    = a_i & b_i;
    pp    = p;
    k     = '0;
    gg[0] = gg[0] | (p[0] & carry_i);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < SLICE_W; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          k     = LEVELS'(i - (1 << l));
          gg[i] = gg[i] | (pp[i] & gg[k]);
          pp[i] = pp[i] & pp[k];
        end
      end
    end
    for (int l = LEVELS - 2; l >= 0; l--) begin
      for (int i = 0; i < SLICE_W; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          k     = LEVELS'(i - (1 << l));
          gg[i] = gg[i] | (pp[i] & gg[k]);
          pp[i] = pp[i] & pp[k];
        end
      end
    end
  end

  assign sum_o   = p ^ {gg[SLICE_W-2:0], carry_i};
  assign carry_o = gg[SLICE_W-1];

endmodule

// File: rtl/bk_sub32_pipe.sv
// Two-stage 32-bit add/subtract/compare unit: low Brent-Kung slice in stage 1,
// high slice plus flags in stage 2, valid/ready on both sides.
module bk_sub32_pipe
  import blu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             lt_u_o,
  output logic             lt_s_o
);

  if (WIDTH != 2 * SLICE_W) begin : g_width_check
    $error("bk_sub32_pipe: WIDTH must be %0d", 2 * SLICE_W);
  end

  function automatic blu_flags_t calc_flags(
    input blu_addsub_e op,
    input logic        res_msb,
    input logic        res_zero,
    input logic        a_msb,
    input logic        b_msb,
    input logic        c_out
  );
    blu_flags_t f;
    f.carry = c_out;
    f.zero  = res_zero;
    f.ovf   = (a_msb == b_msb) && (res_msb != a_msb);
    f.lt_u  = (op == BLU_SUB) ? ~c_out : 1'b0;
    f.lt_s  = (op == BLU_SUB) ? (res_msb ^ f.ovf) : 1'b0;
    return f;
  endfunction

  logic               out_adv;
  logic               in_fire;
  logic [WIDTH-1:0]   b_eff;
  logic [SLICE_W-1:0] lo_sum;
  logic               lo_carry;

  logic               vld_p1;
  logic [SLICE_W-1:0] lo_p1;
  logic               c16_p1;
  logic [SLICE_W-1:0] a_hi_p1;
  logic [SLICE_W-1:0] b_hi_p1;
  blu_addsub_e        op_p1;

  logic [SLICE_W-1:0] hi_sum;
  logic               hi_carry;
  logic [WIDTH-1:0]   result_p1;
  blu_flags_t         flags_p1;

  logic               vld_p2;
  logic [WIDTH-1:0]   result_p2;
  blu_flags_t         flags_p2;

  // No skid buffer: ready looks straight through to the consumer's ready.
  assign out_adv    = ~vld_p2 | out_ready_i;
  assign in_ready_o = ~vld_p1 | out_adv;
  assign in_fire    = in_valid_i & in_ready_o;

  // ---- stage 1: operand inversion and low slice ----
  assign b_eff = op_i ? ~b_i : b_i;

  BK_adder_16bit u_lo (
    .a_i     (a_i[SLICE_W-1:0]),
    .b_i     (b_eff[SLICE_W-1:0]),
    .carry_i (op_i),
    .sum_o   (lo_sum),
    .carry_o (lo_carry)
  );

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      lo_p1   <= lo_sum;
      c16_p1  <= lo_carry;
      a_hi_p1 <= a_i[WIDTH-1:SLICE_W];
      b_hi_p1 <= b_eff[WIDTH-1:SLICE_W];
      op_p1   <= blu_addsub_e'(op_i);
    end
  end

  // ---- stage 2: high slice chained through the registered c16, flags ----
  BK_adder_16bit u_hi (
    .a_i     (a_hi_p1),
    .b_i     (b_hi_p1),
    .carry_i (c16_p1),
    .sum_o   (hi_sum),
    .carry_o (hi_carry)
  );

  assign result_p1 = {hi_sum, lo_p1};
  assign flags_p1  = calc_flags(op_p1, hi_sum[SLICE_W-1], ~|result_p1,
                                a_hi_p1[SLICE_W-1], b_hi_p1[SLICE_W-1], hi_carry);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else begin
      if (in_ready_o) begin
        vld_p1 <= in_valid_i;
      end
      if (out_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result_p2 <= result_p1;
          flags_p2  <= flags_p1;
        end
      end
    end
  end

  // ---- output register ----
  assign out_valid_o = vld_p2;
  assign result_o    = result_p2;
  assign carry_o     = flags_p2.carry;
  assign zero_o      = flags_p2.zero;
  assign ovf_o       = flags_p2.ovf;
  assign lt_u_o      = flags_p2.lt_u;
  assign lt_s_o      = flags_p2.lt_s;

endmodule

// File: tb/tb_bk_sub32_pipe.sv
// Scoreboard bench for bk_sub32_pipe: directed corner cases, back-pressure,
// mid-stream reset and a long randomized valid/ready stream.
module tb_bk_sub32_pipe;

  typedef struct packed {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        ovf;
    logic        lt_u;
    logic        lt_s;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        op_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        carry_o;
  logic        zero_o;
  logic        ovf_o;
  logic        lt_u_o;
  logic        lt_s_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   stall_prev = 1'b0;
  exp_t held;

  bk_sub32_pipe #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .zero_o      (zero_o),
    .ovf_o       (ovf_o),
    .lt_u_o      (lt_u_o),
    .lt_s_o      (lt_s_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [32:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      sr      = sa - sb;
      full    = {1'b0, a} - {1'b0, b};
      e.carry = (a >= b);
    end else begin
      sr      = sa + sb;
      full    = {1'b0, a} + {1'b0, b};
      e.carry = full[32];
    end
    e.result = full[31:0];
    e.zero   = (full[31:0] == 32'd0);
    e.ovf    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.lt_u   = op && (a < b);
    e.lt_s   = op && ($signed(a) < $signed(b));
    return e;
  endfunction

  function automatic exp_t got_now();
    return {result_o, carry_o, zero_o, ovf_o, lt_u_o, lt_s_o};
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    exp_t g;
    g = got_now();
    checks++;
    if (out_valid_o !== 1'b0 || g !== '0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: got valid=%b ready=%b res=%h flags=%b want valid=0 ready=1 res=0 flags=0",
               name, out_valid_o, in_ready_o, g.result, g[4:0]);
    end
  endtask

  // Called at posedge+1; drives one cycle and records an accepted op.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic rdy, input bit use_e, input exp_t e,
                       output bit acc);
    in_valid_i  = v;
    a_i         = a;
    b_i         = b;
    op_i        = op;
    out_ready_i = rdy;
    @(negedge clk_i);
    acc = v && in_ready_o && rst_ni;
    if (acc) exp_q.push_back(use_e ? e : model(a, b, op));
    @(posedge clk_i);
    #1;
  endtask

  // Output monitor: pops on every transfer and checks stall stability.
  always @(negedge clk_i) begin
    exp_t g;
    exp_t e;
    g = got_now();
    if (!rst_ni) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid_o !== 1'b1 || g !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b res=%h flags=%b want valid=1 res=%h flags=%b",
                   out_valid_o, g.result, g[4:0], held.result, held[4:0]);
        end
      end
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got res=%h flags=%b want no output", g.result, g[4:0]);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL result: got res=%h c/z/v/ltu/lts=%b want res=%h c/z/v/ltu/lts=%b",
                     g.result, g[4:0], e.result, e[4:0]);
          end
        end
      end
      stall_prev = out_valid_o && !out_ready_i;
      held       = g;
    end
  end

  logic [31:0] da  [6];
  logic [31:0] db  [6];
  logic        dop [6];
  exp_t        de  [6];
  logic [31:0] ba  [4];
  logic [31:0] bb  [4];
  logic        bo  [4];

  initial begin
    bit acc;
    bit accs [3];
    int idx;
    int cyc;
    int accepted;

    da[0] = 32'h0000_0000; db[0] = 32'h0000_0001; dop[0] = 1'b1;
    de[0] = '{result: 32'hFFFF_FFFF, carry: 1'b0, zero: 1'b0, ovf: 1'b0, lt_u: 1'b1, lt_s: 1'b1};
    da[1] = 32'h7FFF_FFFF; db[1] = 32'h0000_0001; dop[1] = 1'b0;
    de[1] = '{result: 32'h8000_0000, carry: 1'b0, zero: 1'b0, ovf: 1'b1, lt_u: 1'b0, lt_s: 1'b0};
    da[2] = 32'h8000_0000; db[2] = 32'h0000_0001; dop[2] = 1'b1;
    de[2] = '{result: 32'h7FFF_FFFF, carry: 1'b1, zero: 1'b0, ovf: 1'b1, lt_u: 1'b0, lt_s: 1'b1};
    da[3] = 32'h1234_ABCD; db[3] = 32'h1234_ABCD; dop[3] = 1'b1;
    de[3] = '{result: 32'h0000_0000, carry: 1'b1, zero: 1'b1, ovf: 1'b0, lt_u: 1'b0, lt_s: 1'b0};
    da[4] = 32'hFFFF_FFFF; db[4] = 32'h0000_0001; dop[4] = 1'b0;
    de[4] = '{result: 32'h0000_0000, carry: 1'b1, zero: 1'b1, ovf: 1'b0, lt_u: 1'b0, lt_s: 1'b0};
    da[5] = 32'h0000_FFFF; db[5] = 32'h0000_0001; dop[5] = 1'b0;
    de[5] = '{result: 32'h0001_0000, carry: 1'b0, zero: 1'b0, ovf: 1'b0, lt_u: 1'b0, lt_s: 1'b0};

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    a_i         = '0;
    b_i         = '0;
    op_i        = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset_state");
    #2 rst_ni = 1'b1;
    #1 check_bit("ready_after_reset", in_ready_o, 1'b1);
    @(posedge clk_i);
    #1;

    // Directed corners; the first one also measures latency.
    cycle(1'b1, da[0], db[0], dop[0], 1'b1, 1'b1, de[0], acc);
    check_bit("dir_accept_0", acc, 1'b1);
    in_valid_i = 1'b0;
    check_bit("latency_edge1", out_valid_o, 1'b0);
    @(posedge clk_i);
    #1 check_bit("latency_edge2", out_valid_o, 1'b1);
    for (int i = 1; i < 6; i++) begin
      cycle(1'b1, da[i], db[i], dop[i], 1'b1, 1'b1, de[i], acc);
      check_bit("dir_accept", acc, 1'b1);
    end
    repeat (4) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);

    // Back-pressure: consumer stalls for three cycles while four ops queue up.
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
      bo[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b1, ba[idx], bb[idx], bo[idx], 1'b0, 1'b0, '0, acc);
      accs[c] = acc;
      if (acc) idx++;
    end
    check_bit("bp_accept_1", accs[0], 1'b1);
    check_bit("bp_accept_2", accs[1], 1'b1);
    check_bit("bp_blocked_3", accs[2], 1'b0);
    check_bit("bp_ready_low", in_ready_o, 1'b0);
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      cycle(1'b1, ba[idx], bb[idx], bo[idx], 1'b1, 1'b0, '0, acc);
      if (acc) idx++;
      cyc++;
    end
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL bp_all_accepted: got %0d want 4", idx);
    end
    repeat (4) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);

    // Reset with two ops in flight: nothing from before reset may emerge.
    cycle(1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b0, 1'b0, '0, acc);
    cycle(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, '0, acc);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    exp_q.delete();
    #1 check_idle_outputs("mid_reset_state");
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    #1 check_bit("ready_after_mid_reset", in_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
      check_bit("no_stale_output", out_valid_o, 1'b0);
    end

    // Random streaming with random valid and ready.
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      cycle(1'($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) < 7), 1'b0, '0, acc);
      if (acc) accepted++;
      cyc++;
    end
    checks++;
    if (accepted != 10000) begin
      errors++;
      $display("FAIL random_accepts: got %0d want 10000", accepted);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
